// File: rtl/sd_fifo_rx_drainer_if.sv
// ----------------------------------------------------------------------------
// sd_fifo_rx_drainer_if
//   Wishbone write-master bundle used by the SD RX FIFO drainer.
//
//   m_wb_adr_o  32  write address (adr + offset)
//   m_wb_dat_o  32  write data
//   m_wb_sel_o   4  byte selects
//   m_wb_we_o    1  write enable
//   m_wb_cyc_o   1  bus cycle
//   m_wb_stb_o   1  strobe
//   m_wb_ack_i   1  slave acknowledge
//
//   master: the drainer side; slave: the memory side.
// ----------------------------------------------------------------------------
interface sd_fifo_rx_drainer_if;
  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i;

  modport master (
    output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    input  m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    output m_wb_ack_i
  );
endinterface

// File: rtl/sd_fifo_rx_drainer.sv
// ----------------------------------------------------------------------------
// sd_fifo_rx_drainer
//   Pops 4-bit nibbles from the SD RX data FIFO, packs eight of them into a
//   32-bit word (first nibble in bits [3:0]) and writes each word to system
//   memory as a Wishbone master at adr + offset. Two word buffers are used in
//   ping-pong fashion so packing continues while a write waits for ack.
//
// Ports:
//   clk           Wishbone clock
//   rst           asynchronous active-high reset
//   en            transfer enable; low clears all state synchronously
//   adr           base memory address of the block
//   fifo_dat_i    FIFO read data, valid the cycle after fifo_rd_o
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_o     FIFO pop strobe (registered)
//   wb            Wishbone master bundle (sd_fifo_rx_drainer_if.master)
//   busy_o        nibble in flight, word buffered or bus cycle open
//
// Parameters:
//   ADDR_INC  byte increment of offset after every acked write
//   OFFSET_W  offset register width; offset wraps modulo 2**OFFSET_W
//
// Build option:
//   SD_RX_BSWAP_EN  when defined, write data is byte-swapped (big-endian
//                   memory layout); nibble packing order is unchanged.
// ----------------------------------------------------------------------------
module sd_fifo_rx_drainer #(
  parameter int ADDR_INC = 4,
  parameter int OFFSET_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [31:0]          adr,
  input  logic [3:0]           fifo_dat_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_o,
  sd_fifo_rx_drainer_if.master wb,
  output logic                 busy_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [OFFSET_W-1:0] OFFSET_INC = OFFSET_W'(ADDR_INC);

  // Issue side
  logic                rd_reg;
  logic                rd_d_reg;
  logic [2:0]          iss_cnt_reg;
  logic                iss_ptr_reg;
  logic                iss_ptr_next;

  // Capture side and buffers
  logic [2:0]          cap_cnt_reg;
  logic                wr_ptr_reg;
  logic                rd_ptr_reg;
  logic [1:0]          buf_valid_reg;
  logic [31:0]         buf_word_reg [2];

  // Bus side
  state_t              state_reg;
  logic [OFFSET_W-1:0] offset_reg;
  logic                cyc_reg;
  logic                stb_reg;
  logic                we_reg;
  logic [3:0]          sel_reg;
  logic [31:0]         dat_reg;

  logic [31:0]         head_word;
  logic [31:0]         out_word;

  assign head_word = buf_word_reg[rd_ptr_reg];

`ifdef SD_RX_BSWAP_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_bswap
    assign out_word[8*gi +: 8] = head_word[8*(3-gi) +: 8];
  end
`else
  assign out_word = head_word;
`endif

  // The pointer the next pop will fill. Looking at it (rather than the
  // current pointer) keeps the pop that follows the 8th pop of a word from
  // landing in a buffer that is still waiting for the bus.
  assign iss_ptr_next = iss_ptr_reg ^ (rd_reg && (iss_cnt_reg == 3'd7));

  // ------------------------------------------------------------------ issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg      <= 1'b0;
      rd_d_reg    <= 1'b0;
      iss_cnt_reg <= 3'd0;
      iss_ptr_reg <= 1'b0;
    end else if (!en) begin
      rd_reg      <= 1'b0;
      rd_d_reg    <= 1'b0;
      iss_cnt_reg <= 3'd0;
      iss_ptr_reg <= 1'b0;
    end else begin
      rd_reg      <= !fifo_empty_i && !buf_valid_reg[iss_ptr_next];
      rd_d_reg    <= rd_reg;
      iss_ptr_reg <= iss_ptr_next;
      if (rd_reg) begin
        iss_cnt_reg <= iss_cnt_reg + 3'd1;
      end
    end
  end

  // ------------------------------------------------------- capture and bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_cnt_reg     <= 3'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      buf_valid_reg   <= 2'b00;
      buf_word_reg[0] <= 32'd0;
      buf_word_reg[1] <= 32'd0;
      state_reg       <= ST_IDLE;
      offset_reg      <= '0;
      cyc_reg         <= 1'b0;
      stb_reg         <= 1'b0;
      we_reg          <= 1'b0;
      sel_reg         <= 4'h0;
      dat_reg         <= 32'd0;
    end else if (!en) begin
      // Abort: any open cycle is dropped without waiting for ack, and a
      // partially packed word is discarded.
      cap_cnt_reg     <= 3'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      buf_valid_reg   <= 2'b00;
      buf_word_reg[0] <= 32'd0;
      buf_word_reg[1] <= 32'd0;
      state_reg       <= ST_IDLE;
      offset_reg      <= '0;
      cyc_reg         <= 1'b0;
      stb_reg         <= 1'b0;
      we_reg          <= 1'b0;
      sel_reg         <= 4'h0;
      dat_reg         <= 32'd0;
    end else begin
      if (rd_d_reg) begin
        buf_word_reg[wr_ptr_reg][{cap_cnt_reg, 2'b00} +: 4] <= fifo_dat_i;
        cap_cnt_reg <= cap_cnt_reg + 3'd1;
        if (cap_cnt_reg == 3'd7) begin
          buf_valid_reg[wr_ptr_reg] <= 1'b1;
          wr_ptr_reg                <= ~wr_ptr_reg;
        end
      end

      // The set above and the clear below always hit different buffers:
      // a capture can only complete into the buffer the bus is not draining.
      case (state_reg)
        ST_IDLE: begin
          if (buf_valid_reg[rd_ptr_reg]) begin
            cyc_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            we_reg    <= 1'b1;
            sel_reg   <= 4'hF;
            dat_reg   <= out_word;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wb.m_wb_ack_i) begin
            cyc_reg                   <= 1'b0;
            stb_reg                   <= 1'b0;
            we_reg                    <= 1'b0;
            buf_valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg                <= ~rd_ptr_reg;
            offset_reg                <= offset_reg + OFFSET_INC;
            state_reg                 <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd_o     = rd_reg;
  assign wb.m_wb_adr_o = adr + 32'(offset_reg);
  assign wb.m_wb_dat_o = dat_reg;
  assign wb.m_wb_sel_o = sel_reg;
  assign wb.m_wb_we_o  = we_reg;
  assign wb.m_wb_cyc_o = cyc_reg;
  assign wb.m_wb_stb_o = stb_reg;

  assign busy_o = rd_reg || rd_d_reg || (cap_cnt_reg != 3'd0) || (|buf_valid_reg) || cyc_reg;

endmodule

// File: tb/tb_sd_fifo_rx_drainer.sv
// ----------------------------------------------------------------------------
// tb_sd_fifo_rx_drainer
//   Self-checking bench for sd_fifo_rx_drainer. A FIFO model feeds nibbles,
//   a reference model turns every popped nibble into the stream of words that
//   memory must receive (8 nibbles per word, addresses adr + 4*k modulo 512),
//   and a per-cycle compare process checks the bus against it.
// ----------------------------------------------------------------------------
module tb_sd_fifo_rx_drainer;
  localparam int          OFFSET_W = 9;
  localparam logic [31:0] BASE     = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] adr = BASE;
  logic [3:0]  fifo_dat_i = 4'h0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_o;
  logic        busy_o;

  sd_fifo_rx_drainer_if wb ();

  sd_fifo_rx_drainer #(.ADDR_INC(4), .OFFSET_W(OFFSET_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .adr         (adr),
    .fifo_dat_i  (fifo_dat_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rd_o   (fifo_rd_o),
    .wb          (wb),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model state
  logic [3:0]  fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_log_adr[$];
  logic [31:0] wr_log_dat[$];
  logic [31:0] acc = '0;
  int          acc_n = 0;
  int          popped = 0;
  int          acked = 0;
  int          model_off = 0;
  int          total_pops = 0;
  int          cycle_no = 0;
  int          cyc_cnt = 0;
  int          ack_delay = 2;
  bit          prev_acc = 1'b0;
  bit          have_nib = 1'b0;
  logic [3:0]  nib_pend = 4'h0;

  // Stimulus mode flags
  bit chk_en = 1'b0;
  bit hold_ack = 1'b0;
  bit toggle_empty = 1'b0;
  bit rand_empty = 1'b0;
  bit spurious_ack = 1'b0;
  bit rand_delay = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle_no);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] w);
`ifdef SD_RX_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] log_adr(input int i);
    if (i < wr_log_adr.size()) return wr_log_adr[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] log_dat(input int i);
    if (i < wr_log_dat.size()) return wr_log_dat[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    acc       = '0;
    acc_n     = 0;
    popped    = 0;
    acked     = 0;
    model_off = 0;
    cyc_cnt   = 0;
    prev_acc  = 1'b0;
  endtask

  task automatic push_seq(input logic [3:0] first, input int n);
    logic [3:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(v);
      v = v + 4'd1;
    end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(4'($urandom));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_log_adr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("write_count", 32'(wr_log_adr.size() >= n), 32'd1);
  endtask

  // Abort any transfer, start from an empty FIFO and offset 0.
  task automatic restart();
    @(negedge clk);
    chk_en = 1'b0;
    en     = 1'b0;
    cycles(3);
    clear_model();
    chk_en = 1'b1;
    en     = 1'b1;
  endtask

  // FIFO read data follows a pop by one cycle; garbage otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fifo_dat_i = have_nib ? nib_pend : 4'($urandom);
    end
  end

  // FIFO model, Wishbone slave and per-cycle compare.
  initial begin
    wb.m_wb_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      cycle_no++;
      have_nib = 1'b0;
      if (fifo_rd_o) begin
        total_pops++;
        check("no_overread", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) begin
          nib_pend = fifo_q.pop_front();
          have_nib = 1'b1;
          popped++;
          acc = acc | (32'(nib_pend) << (4 * acc_n));
          acc_n++;
          if (acc_n == 8) begin
            exp_q.push_back(mem_word(acc));
            acc   = '0;
            acc_n = 0;
          end
        end
      end
      fifo_empty_i = (fifo_q.size() == 0) ||
                     (rand_empty && ($urandom_range(0, 2) == 0)) ||
                     (toggle_empty && cycle_no[0]);

      if (chk_en) begin
        check("backpressure", 32'((popped - 8 * acked) <= 16), 32'd1);
        check("busy", 32'(busy_o), 32'((popped - 8 * acked) > 0));
        check("idle_gap", 32'(prev_acc && wb.m_wb_cyc_o), 32'd0);
        if (wb.m_wb_cyc_o) begin
          check("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("wr_dat", wb.m_wb_dat_o, exp_q[0]);
          check("wr_adr", wb.m_wb_adr_o, BASE + 32'(model_off));
          check("wr_sel", 32'(wb.m_wb_sel_o), 32'hF);
          check("wr_stb", 32'(wb.m_wb_stb_o), 32'd1);
          check("wr_we", 32'(wb.m_wb_we_o), 32'd1);
        end else begin
          check("stb_idle", 32'(wb.m_wb_stb_o), 32'd0);
        end
      end

      prev_acc = 1'b0;
      if (wb.m_wb_cyc_o && wb.m_wb_stb_o) begin
        cyc_cnt++;
        if (!hold_ack && cyc_cnt >= ack_delay) begin
          wb.m_wb_ack_i = 1'b1;
          prev_acc      = 1'b1;
          cyc_cnt       = 0;
          wr_log_adr.push_back(wb.m_wb_adr_o);
          wr_log_dat.push_back(wb.m_wb_dat_o);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          model_off = (model_off + 4) % (1 << OFFSET_W);
          acked++;
          if (rand_delay) ack_delay = $urandom_range(1, 4);
        end else begin
          wb.m_wb_ack_i = 1'b0;
        end
      end else begin
        cyc_cnt       = 0;
        wb.m_wb_ack_i = spurious_ack && ($urandom_range(0, 3) == 0);
      end
    end
  end

  int L;
  int p0;
  int k;

  initial begin
    // ---------------- reset with en low: nothing moves
    push_seq(4'h1, 8);
    cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_rd", 32'(fifo_rd_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
    end
    check("rst_stb", 32'(wb.m_wb_stb_o), 32'd0);
    check("rst_we", 32'(wb.m_wb_we_o), 32'd0);
    check("rst_sel", 32'(wb.m_wb_sel_o), 32'd0);
    check("rst_dat", wb.m_wb_dat_o, 32'd0);
    check("rst_adr", wb.m_wb_adr_o, BASE);

    // ---------------- single word 1..8, ack one cycle after stb
    restart();
    ack_delay = 2;
    push_seq(4'h1, 8);
    L = wr_log_adr.size();
    wait_writes(L + 1, 200);
    check("w1_adr", log_adr(L), 32'h1000_0000);
`ifdef SD_RX_BSWAP_EN
    check("w1_dat", log_dat(L), 32'h2143_6587);
`else
    check("w1_dat", log_dat(L), 32'h8765_4321);
`endif
    cycles(3);
    check("w1_offset", wb.m_wb_adr_o, 32'h1000_0004);
    check("w1_idle", 32'(busy_o), 32'd0);

    // ---------------- back-pressure: 24 nibbles, ack withheld
    restart();
    hold_ack = 1'b1;
    p0 = total_pops;
    push_rand(24);
    L = wr_log_adr.size();
    cycles(45);
    check("bp_pops", 32'(total_pops - p0), 32'd16);
    check("bp_rd_low", 32'(fifo_rd_o), 32'd0);
    check("bp_cyc_held", 32'(wb.m_wb_cyc_o), 32'd1);
    hold_ack = 1'b0;
    wait_writes(L + 3, 400);
    check("bp_adr0", log_adr(L), 32'h1000_0000);
    check("bp_adr1", log_adr(L + 1), 32'h1000_0004);
    check("bp_adr2", log_adr(L + 2), 32'h1000_0008);
    check("bp_pops_all", 32'(total_pops - p0), 32'd24);

    // ---------------- empty toggling every cycle, 16 nibbles 0..F
    restart();
    toggle_empty = 1'b1;
    push_seq(4'h0, 16);
    L = wr_log_adr.size();
    wait_writes(L + 2, 400);
    toggle_empty = 1'b0;
`ifdef SD_RX_BSWAP_EN
    check("tg_dat0", log_dat(L), 32'h1032_5476);
    check("tg_dat1", log_dat(L + 1), 32'h98BA_DCFE);
`else
    check("tg_dat0", log_dat(L), 32'h7654_3210);
    check("tg_dat1", log_dat(L + 1), 32'hFEDC_BA98);
`endif

    // ---------------- en dropped during a write with 3 nibbles captured
    cycles(3);
    hold_ack = 1'b1;
    p0 = total_pops;
    push_seq(4'h1, 11);
    k = 0;
    while (!((total_pops - p0) == 11 && wb.m_wb_cyc_o) && k < 300) begin
      @(negedge clk);
      k++;
    end
    cycles(3);
    check("ab_in_write", 32'(wb.m_wb_cyc_o), 32'd1);
    check("ab_offset_before", wb.m_wb_adr_o, 32'h1000_0008);
    chk_en = 1'b0;
    en     = 1'b0;
    @(negedge clk);
    check("ab_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
    check("ab_stb", 32'(wb.m_wb_stb_o), 32'd0);
    check("ab_busy", 32'(busy_o), 32'd0);
    check("ab_adr", wb.m_wb_adr_o, BASE);
    hold_ack = 1'b0;
    cycles(2);
    clear_model();
    chk_en = 1'b1;
    en     = 1'b1;
    push_seq(4'h9, 8);
    L = wr_log_adr.size();
    wait_writes(L + 1, 200);
    check("re_adr", log_adr(L), BASE);
`ifdef SD_RX_BSWAP_EN
    check("re_dat", log_dat(L), 32'hA9CB_ED0F);
`else
    check("re_dat", log_dat(L), 32'h0FED_CBA9);
`endif

    // ---------------- random traffic, 129 words, offset wrap
    restart();
    rand_empty   = 1'b1;
    spurious_ack = 1'b1;
    rand_delay   = 1'b1;
    push_rand(129 * 8);
    L = wr_log_adr.size();
    wait_writes(L + 129, 30000);
    check("wrap_first", log_adr(L), BASE);
    check("wrap_last", log_adr(L + 127), 32'h1000_01FC);
    check("wrap_129", log_adr(L + 128), BASE);
    rand_empty   = 1'b0;
    spurious_ack = 1'b0;
    cycles(5);
    check("end_idle", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait loop is bypassed by a broken design.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_fifo_rx_drainer.md
Name: sd_fifo_rx_drainer

Overview:
- Receive-side counterpart of the TX filler in the SD DMA path, clocked on the Wishbone clock.
- Pops 4-bit nibbles from the RX data FIFO read port and packs 8 of them into a 32-bit word.
- Writes each packed word to system memory as a Wishbone master at adr+offset.
- A two-word ping-pong buffer lets nibble packing continue while a bus write is still waiting for ack.

Parameters:
- ADDR_INC, 4: byte increment of offset after each acked write (matches MEM_OFFSET).
- OFFSET_W, 9: offset register width; offset wraps modulo 2^OFFSET_W.

Ports:
- clk  in  1  system/Wishbone clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  transfer enable; low = synchronous abort/clear.
- adr  in  32  base memory address of the block.
- fifo_dat_i  in  4  RX FIFO read data, valid the cycle after fifo_rd_o.
- fifo_empty_i  in  1  RX FIFO empty.
- fifo_rd_o  out  1  RX FIFO pop strobe.
- m_wb_adr_o  out  32  adr + zero-extended offset (combinational).
- m_wb_dat_o  out  32  write data.
- m_wb_sel_o  out  4  byte selects.
- m_wb_we_o  out  1  write enable.
- m_wb_cyc_o  out  1  bus cycle.
- m_wb_stb_o  out  1  strobe.
- m_wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  high while any nibble is in flight, any word is buffered, or a bus cycle is open.

Behaviour:
- Reset and en low:
  - All registered outputs and state go to 0: fifo_rd_o, cyc, stb, we, sel, dat, offset, buffers, valid bits, pointers, counters.
  - While en is low this clearing is synchronous every cycle; an open bus cycle is dropped without waiting for ack.
- Issue side:
  - fifo_rd_o = en & !fifo_empty_i & !buf_valid[iss_ptr]. It is registered so that it asserts one cycle after the conditions hold.
  - Each pop increments the 3-bit iss_cnt; when the 8th pop issues (iss_cnt 7 -> 0), iss_ptr toggles.
- Capture side:
  - rd_d is fifo_rd_o delayed by one cycle. When rd_d is high, fifo_dat_i is written to buf[wr_ptr][4*cap_cnt+3 : 4*cap_cnt] and cap_cnt increments. The first nibble lands in bits [3:0], the 8th in bits [31:28].
  - On the 8th capture, buf_valid[wr_ptr] is set and wr_ptr toggles.
- Back-pressure:
  - Popping stops when the buffer being issued into is still valid, i.e. both words are awaiting the bus.
  - No nibble is ever dropped or overwritten.
- Bus FSM, IDLE -> WRITE -> IDLE:
  - IDLE: if buf_valid[rd_ptr], next cycle cyc=stb=we=1, sel=4'hF, dat=buf[rd_ptr], and the FSM moves to WRITE.
  - WRITE: outputs held stable until m_wb_ack_i. In the ack cycle, cyc/stb/we are cleared (registered, low next cycle), buf_valid[rd_ptr] is cleared, rd_ptr toggles and offset += ADDR_INC. The FSM returns to IDLE.
  - There is at least one idle cycle between writes; no pipelined or burst cycles.
  - m_wb_ack_i is ignored outside WRITE.
- Simultaneous events:
  - The ack clearing buf_valid[x] and a capture setting buf_valid[y] in the same cycle are both honoured; x != y is guaranteed by the pointers.
  - A pop issued while a capture completes in the same cycle is legal.
- Offset wrap: at 2^OFFSET_W - ADDR_INC, the next ack returns offset to 0.
- en deasserted mid-word: the partial word is discarded. A pop in flight whose data arrives after en falls is ignored.

Optional Feature:
- SD_RX_BSWAP_EN defined: m_wb_dat_o is the byte-swapped buffer word {b[7:0], b[15:8], b[23:16], b[31:24]}, giving big-endian memory layout.
- Undefined: the buffer word is driven unmodified. Nibble packing order is the same in both cases.

Test Plan:
- rst high then low with en=0 -> all outputs 0, busy_o=0, no pops with fifo_empty_i=0.
- en=1, adr=0x1000_0000, FIFO holds nibbles 1,2,...,8, ack one cycle after stb -> one write: adr 0x1000_0000, dat 0x8765_4321, sel F; offset becomes 4. With SD_RX_BSWAP_EN: dat 0x2143_6587.
- 24 nibbles available, ack withheld 40 cycles -> exactly 16 pops, then fifo_rd_o stays 0. After acks, the remaining 8 nibbles are popped and writes go to 0x1000_0000, 0x1000_0004, 0x1000_0008 in order.
- fifo_empty_i toggling every cycle while 16 nibbles trickle in -> two correct words; cap_cnt never skips.
- en dropped during WRITE with 3 nibbles captured -> next cycle cyc=stb=0, offset 0, busy_o 0. Re-enable: the first write goes to adr+0 with fresh data.
- 128 consecutive words with OFFSET_W=9 -> the 129th write address wraps to adr+0.
